// File: rtl/decode_pkg.sv
// Shared decode constants and the packed control bundle.
// Imported by the decoder and the decode pipeline stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [2:0] WB_LUI  = 3'b001;
  localparam logic [2:0] WB_LOAD = 3'b010;
  localparam logic [2:0] WB_ALU  = 3'b100;

  localparam logic [4:0] ALU_ADD = 5'b00000;

  typedef struct packed {
    logic       illegal;
    logic       ebreak;
    logic       ecall;
    logic       branch_en;
    logic [2:0] branch_op;
    logic       alu_en;
    logic       alu_pc_en;
    logic       alu_imm_en;
    logic [4:0] alu_op;
    logic       alu_halfop;
    logic       jump_en;
    logic       load_en;
    logic [2:0] load_op;
    logic       store_en;
    logic [3:0] store_len;
    logic       wb_en;
    logic [2:0] wb_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam int OFF_RS2        = 0;
  localparam int OFF_RS1        = 5;
  localparam int OFF_RD         = 10;
  localparam int OFF_WB_SEL     = 15;
  localparam int OFF_WB_EN      = 18;
  localparam int OFF_STORE_LEN  = 19;
  localparam int OFF_STORE_EN   = 23;
  localparam int OFF_LOAD_OP    = 24;
  localparam int OFF_LOAD_EN    = 27;
  localparam int OFF_JUMP_EN    = 28;
  localparam int OFF_ALU_HALFOP = 29;
  localparam int OFF_ALU_OP     = 30;
  localparam int OFF_ALU_IMM_EN = 35;
  localparam int OFF_ALU_PC_EN  = 36;
  localparam int OFF_ALU_EN     = 37;
  localparam int OFF_BRANCH_OP  = 38;
  localparam int OFF_BRANCH_EN  = 41;
  localparam int OFF_ECALL      = 42;
  localparam int OFF_EBREAK     = 43;
  localparam int OFF_ILLEGAL    = 44;

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: instr -> control bundle + immediate.
// Illegal encodings keep their fields but lose all side-effect enables.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign imm = XLEN'($signed(imm32));

  logic is_sh;
  logic sh_ok;
  logic sh32_ok;
  logic op_f7_ok;

  // RV64 shifts borrow funct7[0] as shamt[5]
  assign is_sh = (f3[1:0] == 2'b01);
  assign sh32_ok = !is_sh || (f7 == 7'b0)
                   || (f3[2] && f7 == 7'b0100000);
  assign sh_ok = RV64
    ? (!is_sh || instr[31:26] == 6'b0
       || (f3[2] && instr[31:26] == 6'b010000))
    : sh32_ok;
  assign op_f7_ok = (f7 == 7'b0)
    || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
    || (f7 == 7'b0000001 && HAS_M);

  logic bad;
  ctrl_t c;

  always_comb begin
    c      = '0;
    bad    = 1'b0;
    imm32  = '0;
    c.rd   = instr[11:7];
    c.rs1  = instr[19:15];
    c.rs2  = instr[24:20];
    unique case (1'b1)
      opc == OPC_LUI: begin
        c.wb_en  = 1'b1;
        c.wb_sel = WB_LUI;
        imm32    = imm_u;
      end
      opc == OPC_AUIPC: begin
        c.alu_en     = 1'b1;
        c.alu_pc_en  = 1'b1;
        c.alu_imm_en = 1'b1;
        c.alu_op     = ALU_ADD;
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_ALU;
        imm32        = imm_u;
      end
      opc == OPC_JAL: begin
        c.alu_en     = 1'b1;
        c.alu_pc_en  = 1'b1;
        c.alu_imm_en = 1'b1;
        c.jump_en    = 1'b1;
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_ALU;
        imm32        = imm_j;
      end
      opc == OPC_JALR: begin
        c.alu_en     = 1'b1;
        c.alu_imm_en = 1'b1;
        c.jump_en    = 1'b1;
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_ALU;
        imm32        = imm_i;
      end
      opc == OPC_BRANCH: begin
        c.branch_en = 1'b1;
        c.branch_op = f3;
        imm32       = imm_b;
      end
      opc == OPC_LOAD: begin
        c.alu_en     = 1'b1;
        c.alu_imm_en = 1'b1;
        c.load_en    = 1'b1;
        c.load_op    = f3;
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_LOAD;
        imm32        = imm_i;
        bad = !RV64 && (f3 == 3'b011 || f3 == 3'b110);
      end
      opc == OPC_STORE: begin
        c.alu_en     = 1'b1;
        c.alu_imm_en = 1'b1;
        c.store_en   = 1'b1;
        c.store_len  = 4'b0001 << f3[1:0];
        imm32        = imm_s;
        bad = !RV64 && (f3 == 3'b011);
      end
      opc == OPC_OPIMM, opc == OPC_OPIMM32: begin
        c.alu_en     = 1'b1;
        c.alu_imm_en = 1'b1;
        c.alu_op     = is_sh ? {f7[5], 1'b0, f3}
                             : {2'b00, f3};
        c.alu_halfop = (opc == OPC_OPIMM32);
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_ALU;
        imm32        = imm_i;
        bad = (opc == OPC_OPIMM) ? !sh_ok
                                 : (!RV64 || !sh32_ok);
      end
      opc == OPC_OP, opc == OPC_OP32: begin
        c.alu_en     = 1'b1;
        c.alu_op     = {f7[5], f7[0], f3};
        c.alu_halfop = (opc == OPC_OP32);
        c.wb_en      = 1'b1;
        c.wb_sel     = WB_ALU;
        bad = !op_f7_ok || (opc == OPC_OP32 && !RV64);
      end
      opc == OPC_SYSTEM: begin
        c.ebreak = (instr == INSTR_EBREAK);
        c.ecall  = (instr == INSTR_ECALL);
        bad = !c.ebreak && !c.ecall;
      end
      default: bad = 1'b1;
    endcase
    c.illegal = bad;
    if (bad) begin
      c.wb_en     = 1'b0;
      c.store_en  = 1'b0;
      c.load_en   = 1'b0;
      c.jump_en   = 1'b0;
      c.branch_en = 1'b0;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer, flush and
// a saturating counter of illegal instructions handed to execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_imm,
  output logic [CNT_W-1:0]  illegal_cnt
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  decode_comb #(
    .XLEN  (XLEN),
    .HAS_M (HAS_M)
  ) u_dec (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  logic            main_valid;
  ctrl_t           main_ctrl;
  logic [XLEN-1:0] main_imm;
  logic [XLEN-1:0] main_pc;
  logic            skid_valid;
  ctrl_t           skid_ctrl;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_pc;

  logic acc_in;
  logic acc_out;
  logic main_free;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = main_valid && out_ready;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_imm   <= '0;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // skid full implies in_ready=0, so no new beat competes
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_imm   <= skid_imm;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= acc_in;
        if (acc_in) begin
          main_ctrl <= dec_ctrl;
          main_imm  <= dec_imm;
          main_pc   <= in_pc;
        end
      end
    end else if (acc_in) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_imm   <= dec_imm;
      skid_pc    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (!flush && acc_out && main_ctrl.illegal
                 && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_pc   = main_pc;
  assign out_ctrl = main_ctrl;
  assign out_imm  = main_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Bench: RV64+M and RV32-no-M instances share stimulus; a FIFO-level
// model plus an ISA-level decoder predict every output each cycle.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic              in_ready0, out_valid0;
  logic [63:0]       out_pc0, out_imm0;
  logic [CTRL_W-1:0] out_ctrl0;
  logic [15:0]       cnt0;

  logic              in_ready1, out_valid1;
  logic [31:0]       out_pc1, out_imm1;
  logic [CTRL_W-1:0] out_ctrl1;
  logic [1:0]        cnt1;

  ctrl_t k0, k1;
  assign k0 = out_ctrl0;
  assign k1 = out_ctrl1;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .HAS_M(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .out_ctrl(out_ctrl0),
    .out_imm(out_imm0), .illegal_cnt(cnt0)
  );

  decode_stage #(.XLEN(32), .HAS_M(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .out_ctrl(out_ctrl1),
    .out_imm(out_imm1), .illegal_cnt(cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // ISA-level reference decoder
  function automatic void ref_dec(input logic [31:0] w, input bit rv64,
                                  input bit hm, output ctrl_t c,
                                  output logic [63:0] im);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [11:0] i12, s12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] u32;
    bit ill, shift, f7ok;
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    i12 = w[31:20];
    s12 = {w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    u32 = {w[31:12], 12'h000};
    c = '0; im = '0; ill = 0;
    c.rd = w[11:7]; c.rs1 = w[19:15]; c.rs2 = w[24:20];
    shift = (f3 == 3'd1 || f3 == 3'd5);
    f7ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5))
           || (f7 == 7'h01 && hm);
    case (op)
      7'h37: begin c.wb_en = 1; c.wb_sel = 3'b001;
        im = 64'($signed(u32)); end
      7'h17: begin c.alu_en = 1; c.alu_pc_en = 1; c.alu_imm_en = 1;
        c.wb_en = 1; c.wb_sel = 3'b100; im = 64'($signed(u32)); end
      7'h6f: begin c.alu_en = 1; c.alu_pc_en = 1; c.alu_imm_en = 1;
        c.jump_en = 1; c.wb_en = 1; c.wb_sel = 3'b100;
        im = 64'($signed(j21)); end
      7'h67: begin c.alu_en = 1; c.alu_imm_en = 1; c.jump_en = 1;
        c.wb_en = 1; c.wb_sel = 3'b100; im = 64'($signed(i12)); end
      7'h63: begin c.branch_en = 1; c.branch_op = f3;
        im = 64'($signed(b13)); end
      7'h03: begin c.alu_en = 1; c.alu_imm_en = 1; c.load_en = 1;
        c.load_op = f3; c.wb_en = 1; c.wb_sel = 3'b010;
        im = 64'($signed(i12));
        ill = !rv64 && (f3 == 3 || f3 == 6); end
      7'h23: begin c.alu_en = 1; c.alu_imm_en = 1; c.store_en = 1;
        case (f3[1:0])
          2'd0: c.store_len = 4'b0001;
          2'd1: c.store_len = 4'b0010;
          2'd2: c.store_len = 4'b0100;
          default: c.store_len = 4'b1000;
        endcase
        im = 64'($signed(s12)); ill = !rv64 && f3 == 3; end
      7'h13, 7'h1b: begin c.alu_en = 1; c.alu_imm_en = 1;
        c.alu_op = shift ? {f7[5], 1'b0, f3} : {2'b00, f3};
        c.alu_halfop = (op == 7'h1b);
        c.wb_en = 1; c.wb_sel = 3'b100; im = 64'($signed(i12));
        if (op == 7'h1b) ill = !rv64;
        if (shift) begin
          if (rv64 && op == 7'h13)
            ill = !(w[31:26] == 0 || (f3 == 5 && w[31:26] == 6'h10));
          else
            ill = ill || !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
        end
      end
      7'h33, 7'h3b: begin c.alu_en = 1;
        c.alu_op = {f7[5], f7[0], f3}; c.alu_halfop = (op == 7'h3b);
        c.wb_en = 1; c.wb_sel = 3'b100;
        ill = !f7ok || (op == 7'h3b && !rv64); end
      7'h73: begin c.ebreak = (w == 32'h0010_0073);
        c.ecall = (w == 32'h0000_0073);
        ill = !(c.ebreak || c.ecall); end
      default: ill = 1;
    endcase
    c.illegal = ill;
    if (ill) begin
      c.wb_en = 0; c.store_en = 0; c.load_en = 0;
      c.jump_en = 0; c.branch_en = 0;
    end
  endfunction

  typedef struct {
    ctrl_t       c0, c1;
    logic [63:0] i0, i1, pc;
  } beat_t;

  beat_t       mq[$];
  int          mcnt0, mcnt1;
  logic [63:0] got_pcs[$];

  // Stage seen as a 2-deep FIFO: ready while fewer than two beats held
  always @(posedge clk) begin
    beat_t b;
    bit acc, pop;
    if (rst) begin
      mq.delete(); mcnt0 = 0; mcnt1 = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      if (flush) mq.delete();
      else begin
        if (pop) begin
          if (mq[0].c0.illegal && mcnt0 < 65535) mcnt0++;
          if (mq[0].c1.illegal && mcnt1 < 3) mcnt1++;
          void'(mq.pop_front());
        end
        if (acc) begin
          ref_dec(in_instr, 1'b1, 1'b1, b.c0, b.i0);
          ref_dec(in_instr, 1'b0, 1'b0, b.c1, b.i1);
          b.pc = in_pc;
          mq.push_back(b);
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst && out_valid0 && out_ready) got_pcs.push_back(out_pc0);

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready0", in_ready0, mq.size() < 2);
      chk("m_in_ready1", in_ready1, mq.size() < 2);
      chk("m_out_valid0", out_valid0, mq.size() > 0);
      chk("m_out_valid1", out_valid1, mq.size() > 0);
      chk("m_cnt0", cnt0, mcnt0);
      chk("m_cnt1", cnt1, mcnt1);
      if (mq.size() > 0) begin
        chk("m_pc0", out_pc0, mq[0].pc);
        chk("m_pc1", out_pc1, mq[0].pc[31:0]);
        chk("m_ctrl0", out_ctrl0, mq[0].c0);
        chk("m_ctrl1", out_ctrl1, mq[0].c1);
        chk("m_imm0", out_imm0, mq[0].i0);
        chk("m_imm1", out_imm1, mq[0].i1[31:0]);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    bit acc;
    int n;
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      @(posedge clk); acc = in_ready0;
      @(negedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_instr = '0; in_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_cnt", cnt0, 0);
    chk("rst_ctrl", out_ctrl0, 0);
    chk("rst_imm", out_imm0, 0);
    chk("rst_pc", out_pc0, 0);
    #1 rst = 0; out_ready = 1;
    step();

    send(32'h0050_0093, 64'h100);
    chk("addi_valid", out_valid0, 1);
    chk("addi_imm_en", k0.alu_imm_en, 1);
    chk("addi_aluop", k0.alu_op, 5'b00000);
    chk("addi_wb_en", k0.wb_en, 1);
    chk("addi_wb_sel", k0.wb_sel, 3'b100);
    chk("addi_rd", k0.rd, 1);
    chk("addi_imm", out_imm0, 5);
    chk("addi_illegal", k0.illegal, 0);

    send(32'h0020_B423, 64'h104);
    chk("sd_store_en", k0.store_en, 1);
    chk("sd_store_len", k0.store_len, 4'b1000);
    chk("sd_imm", out_imm0, 8);
    chk("sd_wb_en", k0.wb_en, 0);
    chk("sd32_illegal", k1.illegal, 1);
    chk("sd32_store_en", k1.store_en, 0);
    step();
    chk("sd32_cnt", cnt1, 1);

    send(32'h0220_81B3, 64'h108);
    chk("mul_aluop", k0.alu_op, 5'b01000);
    chk("mul_illegal", k0.illegal, 0);
    chk("mul_nom_illegal", k1.illegal, 1);
    chk("mul_nom_wb_en", k1.wb_en, 0);

    send(32'h0020_81BB, 64'h10c);
    chk("addw_halfop", k0.alu_halfop, 1);
    chk("addw_illegal", k0.illegal, 0);

    send(32'hFFFF_F0B7, 64'h110);
    chk("lui_imm", out_imm0, 64'hFFFF_FFFF_FFFF_F000);
    chk("lui_wb_sel", k0.wb_sel, 3'b001);
    chk("lui32_imm", out_imm1, 32'hFFFF_F000);

    send(32'hFE00_0EE3, 64'h114);
    chk("beq_imm", out_imm0, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch_en", k0.branch_en, 1);

    send(32'h0010_0073, 64'h118);
    chk("ebreak", k0.ebreak, 1);
    chk("ebreak_illegal", k0.illegal, 0);
    send(32'h0000_0073, 64'h11c);
    chk("ecall", k0.ecall, 1);
    send(32'h3020_0073, 64'h120);
    chk("mret_illegal", k0.illegal, 1);
    send(32'h0000_0000, 64'h124);
    chk("zero_illegal", k0.illegal, 1);
    repeat (3) step();
    chk("cnt1_sat", cnt1, 3);
    chk("cnt0_final", cnt0, 2);

    got_pcs.delete();
    out_ready = 0;
    send(32'h0010_0113, 64'hA0);
    send(32'h0020_0193, 64'hB0);
    chk("skid_full_ready", in_ready0, 0);
    out_ready = 1;
    send(32'h0030_0213, 64'hC0);
    repeat (3) step();
    chk("order_n", got_pcs.size(), 3);
    if (got_pcs.size() == 3) begin
      chk("order_a", got_pcs[0], 64'hA0);
      chk("order_b", got_pcs[1], 64'hB0);
      chk("order_c", got_pcs[2], 64'hC0);
    end

    got_pcs.delete();
    out_ready = 0;
    send(32'h0040_0293, 64'hD0);
    send(32'h0050_0313, 64'hE0);
    chk("pre_flush_valid", out_valid0, 1);
    in_valid = 1; in_instr = 32'h0060_0393; in_pc = 64'hF0;
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid0, 0);
    chk("flush_ready", in_ready0, 1);
    out_ready = 1;
    repeat (4) step();
    chk("flush_drop", got_pcs.size(), 0);

    send(32'h0070_0413, 64'h200);
    send(32'h0080_0493, 64'h204);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
